// File: rtl/maxnet_pkg.sv
// MAXNET engine shared types and width helpers.
// Optional iteration limit: define MAXNET_ITER_LIMIT_EN.
package maxnet_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sum_w(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int prod_w(input int ew, input int sw);
    return ew + sw;
  endfunction

endpackage

// File: rtl/maxnet_pu.sv
// MAXNET per-channel update: a - floor(eps*(S-a)), clamped at zero.
// Combinational; full-precision product, truncated only by the final shift.
module maxnet_pu
  import maxnet_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EPS_W  = 8,
  parameter int SUM_W  = 34
) (
  input  logic [DATA_W-1:0] a,
  input  logic [SUM_W-1:0]  sum,
  input  logic [EPS_W-1:0]  eps,
  output logic [DATA_W-1:0] a_next
);

  localparam int PROD_W = prod_w(EPS_W, SUM_W);

  logic [SUM_W-1:0]  rest;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  inh;

  always_comb begin
    rest   = sum - SUM_W'(a);
    prod   = PROD_W'(eps) * PROD_W'(rest);
    inh    = prod[PROD_W-1 -: SUM_W];
    a_next = (inh >= SUM_W'(a)) ? '0 : a - inh[DATA_W-1:0];
  end

endmodule

// File: rtl/maxnet_engine.sv
// MAXNET winner-take-all engine: iterates lateral inhibition until <=1 survivor.
// Optional iteration limit with timeout: define MAXNET_ITER_LIMIT_EN.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int EPS_W    = 8,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [EPS_W-1:0]      eps_in,
  input  logic [N*DATA_W-1:0]   x_in,
  output logic                  busy,
  output logic                  done,
  output logic [idx_w(N)-1:0]   winner_idx,
  output logic [DATA_W-1:0]     winner_val,
  output logic                  no_winner,
  output logic                  timeout,
  output logic [ITER_W-1:0]     iter_count
);

  localparam int IDX_W = idx_w(N);
  localparam int SUM_W = sum_w(DATA_W, N);
  localparam int CNT_W = $clog2(N + 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] x_reg [N];
  logic [DATA_W-1:0] a_reg [N];
  logic [DATA_W-1:0] a_nx  [N];
  logic [EPS_W-1:0]  eps_reg;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  nz_cnt;
  logic [IDX_W-1:0]  first_idx;
  logic              found;
  logic              resolve;
  logic              expire;

  for (genvar g = 0; g < N; g++) begin : g_pu
    maxnet_pu #(
      .DATA_W(DATA_W),
      .EPS_W (EPS_W),
      .SUM_W (SUM_W)
    ) u_pu (
      .a     (a_reg[g]),
      .sum   (sum),
      .eps   (eps_reg),
      .a_next(a_nx[g])
    );
  end

  // Sum, survivor count and lowest-index survivor in one pass.
  always_comb begin
    sum       = '0;
    nz_cnt    = '0;
    first_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SUM_W'(a_reg[i]);
      if (a_reg[i] != '0) begin
        nz_cnt = nz_cnt + CNT_W'(1);
        if (!found) begin
          first_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
  end

  assign resolve = (nz_cnt <= CNT_W'(1));

`ifdef MAXNET_ITER_LIMIT_EN
  assign expire = (iter_count == ITER_W'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (state == S_ITER && (resolve || expire)) begin
      timeout <= !resolve;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_ITER;
      S_ITER: if (resolve || expire) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      eps_reg    <= '0;
      iter_count <= '0;
      winner_idx <= '0;
      winner_val <= '0;
      no_winner  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        a_reg[i] <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            eps_reg    <= eps_in;
            iter_count <= '0;
            for (int i = 0; i < N; i++) begin
              x_reg[i] <= x_in[i*DATA_W +: DATA_W];
              a_reg[i] <= x_in[i*DATA_W +: DATA_W];
            end
          end
        end
        S_ITER: begin
          if (resolve) begin
            winner_idx <= first_idx;
            winner_val <= (nz_cnt == '0) ? '0 : x_reg[first_idx];
            no_winner  <= (nz_cnt == '0);
          end else if (expire) begin
            winner_idx <= first_idx;
            winner_val <= x_reg[first_idx];
            no_winner  <= 1'b0;
          end else begin
            for (int i = 0; i < N; i++) a_reg[i] <= a_nx[i];
            iter_count <= (&iter_count) ? iter_count
                                        : iter_count + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/maxnet_engine.md
MAXNET_ENGINE -- requirements
Module: maxnet_engine

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning channel count (N >= 2).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning unsigned input/activation width.
REQ-003 The module SHALL have parameter EPS_W, default 8, meaning inhibition-weight width; eps = eps_in / 2^EPS_W.
REQ-004 The module SHALL have parameters ITER_W, default 8, meaning iteration-counter width, and MAX_ITER, default 255, meaning the iteration limit.
REQ-005 The module SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-006 The module SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit, meaning a run request, sampled only in IDLE.
REQ-008 The module SHALL have ports eps_in, input, EPS_W bits, meaning the inhibition weight, and x_in, input, N*DATA_W bits, meaning the inputs with channel i at bits [i*DATA_W +: DATA_W]; both are sampled with start.
REQ-009 The module SHALL have ports busy, output, 1 bit, and done, output, 1 bit; done is a one-cycle pulse.
REQ-010 The module SHALL have ports winner_idx, output, clog2(N) bits, and winner_val, output, DATA_W bits, meaning the original x of the winner.
REQ-011 The module SHALL have ports no_winner, timeout, output, 1 bit each, and iter_count, output, ITER_W bits.

Function
REQ-012 The FSM SHALL have the states IDLE, ITER and DONE, with transitions IDLE->ITER on start, ITER->DONE on resolution or timeout, and DONE->IDLE unconditionally.
REQ-013 On the start edge, x_in SHALL be captured into x_reg[i], a_reg[i] SHALL be set to x_in[i], eps_in SHALL be latched, and iter_count SHALL be set to 0.
REQ-014 Each ITER cycle SHALL first count nonzero a_reg: if the count is <= 1, the FSM goes to DONE with no update; otherwise all a_reg update simultaneously and iter_count increments.
REQ-015 The update SHALL be S = sum of a_reg (DATA_W+clog2(N) bits); inh_i = floor(eps*(S - a_reg[i])); a_reg[i] <= (inh_i >= a_reg[i]) ? 0 : a_reg[i] - inh_i.
REQ-016 The update SHALL be computed without overflow at full precision; only the final shift by EPS_W truncates.
REQ-017 Latency SHALL be as follows: with start high in cycle 0 and k update iterations, done is high in cycle 2+k.
REQ-018 At resolution with exactly one nonzero channel, winner_idx SHALL be that index, winner_val = x_reg[idx], and no_winner = 0.
REQ-019 At resolution with zero nonzero channels (all-zero input, or an exact tie collapsing together), the outputs SHALL be no_winner = 1, winner_idx = 0 and winner_val = 0.
REQ-020 busy SHALL be high in ITER and DONE; start SHALL be ignored while busy.
REQ-021 Result outputs SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-022 start asserted in the same cycle as done SHALL be ignored; a new run SHALL be accepted in IDLE the following cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and clear all registers; all outputs SHALL be 0.
REQ-024 Reset mid-run SHALL abort the run with no done pulse; the next run SHALL require a fresh start.

Configuration
REQ-025 With MAXNET_ITER_LIMIT_EN defined, if iter_count reaches MAX_ITER in ITER with more than one nonzero channel, the FSM SHALL go to DONE with timeout = 1, winner_idx = lowest-index nonzero channel, and winner_val equal to its x_reg.
REQ-026 Without MAXNET_ITER_LIMIT_EN, no limit logic SHALL exist, timeout SHALL be tied to 0, and iter_count SHALL saturate at all-ones.

Structure
REQ-027 maxnet_pkg SHALL hold the FSM state enum and the width helper constants (index width, sum width, product width).
REQ-028 One sub-module, maxnet_pu, SHALL be instantiated N times; each instance is combinational and takes a_reg[i], S and eps, and produces the next a_reg[i].
REQ-029 The engine SHALL own the FSM, the registers, nonzero counting, winner priority encoding and the iteration counter.

Verification (N=4, DATA_W=8, EPS_W=8)
REQ-030 Stimulus x={10,20,30,40}, eps=64 with start in cycle 0 -> required response: 4 iterations, done in cycle 6, winner_idx=3, winner_val=40, iter_count=4.
REQ-031 Stimulus x={0,0,0,0} -> required response: done in cycle 2, no_winner=1, iter_count=0.
REQ-032 Stimulus x={0,0,77,0} -> required response: done in cycle 2, winner_idx=2, winner_val=77, no_winner=0.
REQ-033 Stimulus x={50,50,0,0}, eps=128, MAXNET_ITER_LIMIT_EN, MAX_ITER=16 -> required response: timeout=1, winner_idx=0, winner_val=50, iter_count=16.
REQ-034 Stimulus rst_n low in cycle 3 of the REQ-030 run -> required response: no done pulse, all outputs 0, busy=0; a restart gives results identical to REQ-030.
REQ-035 Stimulus start held high through a run -> required response: exactly one run per IDLE visit, no start accepted while busy.
